// File: rtl/conv_window_feeder_pkg.sv
// Shared constants and types for the convolution window feeder.
// Window geometry, the feeder state encoding and the window-count helper.
package conv_window_feeder_pkg;

    localparam int WIN_SIZE   = 6;
    localparam int WIN_STRIDE = 2;
    localparam int WIN_PIX    = WIN_SIZE * WIN_SIZE;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } feeder_state_e;

    // Number of window positions along one image dimension.
    function automatic int win_count(input int extent);
        return (extent - WIN_SIZE) / WIN_STRIDE + 1;
    endfunction

endpackage

// File: rtl/conv_window_feeder_mux.sv
// Selects the 6x6 window whose top-left corner is (win_row, win_col)
// out of the full frame store.
module window_mux6x6
    import conv_window_feeder_pkg::*;
#(
    parameter int IMG_W = 12,
    parameter int IMG_H = 12
) (
    input  logic [IMG_H-1:0][IMG_W-1:0] store,
    input  logic [$clog2(IMG_H)-1:0]    win_row,
    input  logic [$clog2(IMG_W)-1:0]    win_col,
    output logic                        image [0:WIN_PIX-1]
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    for (genvar dy = 0; dy < WIN_SIZE; dy++) begin : g_row
        for (genvar dx = 0; dx < WIN_SIZE; dx++) begin : g_col
            logic [RW-1:0] row_s;
            logic [CW-1:0] col_s;
            assign row_s = win_row + RW'(dy);
            assign col_s = win_col + CW'(dx);
            assign image[WIN_SIZE*dy+dx] = store[row_s][col_s];
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Buffers one binary frame, then streams its 6x6 windows at stride 2 in
// raster order to a downstream conv/pool stage with valid/ready handshake.
module conv_window_feeder
    import conv_window_feeder_pkg::*;
#(
    parameter int IMG_W = 12,
    parameter int IMG_H = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_in,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    output logic                     image [0:WIN_PIX-1],
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     frame_done
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    localparam logic [RW-1:0] LOAD_ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] LOAD_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] WIN_ROW_LAST  = RW'((win_count(IMG_H) - 1) * WIN_STRIDE);
    localparam logic [CW-1:0] WIN_COL_LAST  = CW'((win_count(IMG_W) - 1) * WIN_STRIDE);
    localparam logic [RW-1:0] ROW_STEP      = RW'(WIN_STRIDE);
    localparam logic [CW-1:0] COL_STEP      = CW'(WIN_STRIDE);

    feeder_state_e              state_r;
    feeder_state_e              state_next_s;
    logic [RW-1:0]              load_row_r;
    logic [CW-1:0]              load_col_r;
    logic [RW-1:0]              win_row_r;
    logic [CW-1:0]              win_col_r;
    logic [IMG_H-1:0][IMG_W-1:0] store_r;

    logic pix_accept_s;
    logic win_accept_s;
    logic last_pix_s;
    logic last_win_s;

    assign pix_accept_s = pix_valid && (state_r == ST_LOAD);
    assign win_accept_s = win_ready && (state_r == ST_EMIT);
    assign last_pix_s   = (load_row_r == LOAD_ROW_LAST) && (load_col_r == LOAD_COL_LAST);
    assign last_win_s   = (win_row_r == WIN_ROW_LAST) && (win_col_r == WIN_COL_LAST);

    assign win_row = win_row_r;
    assign win_col = win_col_r;

    // Next-state logic and state-decoded handshake/status outputs.
    always_comb begin
        state_next_s = state_r;
        pix_ready    = 1'b0;
        win_valid    = 1'b0;
        frame_done   = 1'b0;
        case (state_r)
            ST_LOAD: begin
                pix_ready = 1'b1;
                if (pix_accept_s && last_pix_s) begin
                    state_next_s = ST_EMIT;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_EMIT: begin
                win_valid = 1'b1;
                if (win_accept_s && last_win_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                frame_done   = 1'b1;
                state_next_s = ST_LOAD;
            end
            default: begin
                state_next_s = ST_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Raster load position; cleared on the last pixel so the next frame starts at (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_row_r <= '0;
            load_col_r <= '0;
        end else if (pix_accept_s) begin
            if (last_pix_s) begin
                load_row_r <= '0;
                load_col_r <= '0;
            end else if (load_col_r == LOAD_COL_LAST) begin
                load_row_r <= load_row_r + RW'(1);
                load_col_r <= '0;
            end else begin
                load_col_r <= load_col_r + CW'(1);
            end
        end
    end

    // Window position advances only on an accepted window, giving hold-while-stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_row_r <= '0;
            win_col_r <= '0;
        end else if (win_accept_s) begin
            if (win_col_r == WIN_COL_LAST) begin
                win_col_r <= '0;
                win_row_r <= last_win_s ? '0 : (win_row_r + ROW_STEP);
            end else begin
                win_col_r <= win_col_r + COL_STEP;
            end
        end
    end

    // Frame store; reset wipes any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_r <= '0;
        end else if (pix_accept_s) begin
            store_r[load_row_r][load_col_r] <= pix_in;
        end
    end

    window_mux6x6 #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) u_mux (
        .store  (store_r),
        .win_row(win_row_r),
        .win_col(win_col_r),
        .image  (image)
    );

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench: random and directed frames against a frame/window model.
module tb_conv_window_feeder;

    localparam int W    = 12;
    localparam int H    = 12;
    localparam int NC   = (W - 6) / 2 + 1;
    localparam int NR   = (H - 6) / 2 + 1;
    localparam int NWIN = NC * NR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_in = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic       image [0:35];
    logic       win_valid;
    logic       win_ready = 1'b0;
    logic [3:0] win_row;
    logic [3:0] win_col;
    logic       frame_done;

    logic       pix_in6 = 1'b0;
    logic       pix_valid6 = 1'b0;
    logic       pix_ready6;
    logic       image6 [0:35];
    logic       win_valid6;
    logic       win_ready6 = 1'b0;
    logic [2:0] win_row6;
    logic [2:0] win_col6;
    logic       frame_done6;

    int          total = 0;
    int          bad = 0;
    bit          refm [H][W];
    bit          ref6 [6][6];
    logic [35:0] img_v;
    logic [35:0] img6_v;
    logic [35:0] e6;

    conv_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .image(image), .win_valid(win_valid),
        .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
        .frame_done(frame_done)
    );

    conv_window_feeder #(.IMG_W(6), .IMG_H(6)) dut6 (
        .clk(clk), .rst(rst), .pix_in(pix_in6), .pix_valid(pix_valid6),
        .pix_ready(pix_ready6), .image(image6), .win_valid(win_valid6),
        .win_ready(win_ready6), .win_row(win_row6), .win_col(win_col6),
        .frame_done(frame_done6)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 36; i++) begin
            img_v[i]  = image[i];
            img6_v[i] = image6[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] exp_win(input int r, input int c);
        logic [35:0] v;
        for (int dy = 0; dy < 6; dy++)
            for (int dx = 0; dx < 6; dx++)
                v[6*dy+dx] = refm[r+dy][c+dx];
        return v;
    endfunction

    // kind: 0 random pixels with random gaps, 1 all ones, 2 checkerboard (r+c)&1
    task automatic load_frame(input int kind, input int npix, input bit hold_valid);
        int n = 0;
        int cyc = 0;
        bit pv;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                refm[r][c] = (kind == 1) ? 1'b1 : (kind == 2) ? bit'((r + c) & 1) : bit'($urandom_range(0, 1));
        while (n < npix && cyc < 2000) begin
            pv = (kind == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_valid = pv;
            pix_in    = pv ? refm[n / W][n % W] : 1'($urandom_range(0, 1));
            win_ready = 1'($urandom_range(0, 1));
            chk("load_pix_ready", pix_ready, 1);
            chk("load_win_valid", win_valid, 0);
            step();
            if (pv) n++;
            cyc++;
        end
        chk("load_count", n, npix);
        pix_valid = hold_valid;
        win_ready = 1'b0;
        if (npix == H * W) chk("emit_pix_ready", pix_ready, 0);
    endtask

    // mode: 0 always ready, 1 ready pattern 1-0-0-1, 2 random ready
    task automatic run_emit(input int mode, input int stop_after, input bit garbage);
        int idx = 0;
        int cyc = 0;
        int er;
        int ec;
        while (idx < stop_after && cyc < 500) begin
            er = (idx / NC) * 2;
            ec = (idx % NC) * 2;
            case (mode)
                0:       win_ready = 1'b1;
                1:       win_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: win_ready = 1'($urandom_range(0, 1));
            endcase
            if (garbage) pix_in = 1'($urandom_range(0, 1));
            chk("win_valid", win_valid, 1);
            chk("win_row", win_row, er);
            chk("win_col", win_col, ec);
            chk("image", img_v, exp_win(er, ec));
            chk("emit_pix_ready", pix_ready, 0);
            chk("emit_frame_done", frame_done, 0);
            step();
            if (win_ready) idx++;
            cyc++;
        end
        chk("win_count", idx, stop_after);
        if (stop_after == NWIN) begin
            win_ready = 1'b1;
            chk("done_pulse", frame_done, 1);
            chk("done_win_valid", win_valid, 0);
            chk("done_pix_ready", pix_ready, 0);
            step();
            chk("after_done_pulse", frame_done, 0);
            chk("after_done_pix_ready", pix_ready, 1);
            chk("after_done_win_valid", win_valid, 0);
            chk("after_done_row", win_row, 0);
            chk("after_done_col", win_col, 0);
        end
        win_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        #1;
        chk("rst_win_valid", win_valid, 0);
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_frame_done", frame_done, 0);
        step();
        rst = 1'b0;
        chk("rst_row", win_row, 0);
        chk("rst_col", win_col, 0);
        chk("rst_store_clear", img_v, 0);
        step();
        chk("post_rst_pix_ready", pix_ready, 1);
        chk("post_rst_win_valid", win_valid, 0);
    endtask

    initial begin
        do_reset();
        chk("rst6_pix_ready", pix_ready6, 1);
        chk("rst6_win_valid", win_valid6, 0);
        chk("rst6_store_clear", img6_v, 0);

        // checkerboard, full throughput
        load_frame(2, H * W, 1'b0);
        chk("cb_img0", img_v[0], 0);
        chk("cb_img1", img_v[1], 1);
        run_emit(0, NWIN, 1'b0);

        // checkerboard, stalling downstream
        load_frame(2, H * W, 1'b0);
        run_emit(1, NWIN, 1'b0);

        // pix_valid held high through EMIT/DONE, then a second frame
        load_frame(0, H * W, 1'b1);
        run_emit(2, NWIN, 1'b1);
        load_frame(0, H * W, 1'b0);
        run_emit(0, NWIN, 1'b0);

        repeat (2) begin
            load_frame(0, H * W, 1'b0);
            run_emit(2, NWIN, 1'b0);
        end

        // reset mid-load, then an all-ones frame
        load_frame(0, 70, 1'b0);
        do_reset();
        load_frame(1, H * W, 1'b0);
        run_emit(0, NWIN, 1'b0);

        // reset mid-emit after five windows
        load_frame(0, H * W, 1'b0);
        run_emit(0, 5, 1'b0);
        do_reset();
        load_frame(0, H * W, 1'b0);
        run_emit(2, NWIN, 1'b0);

        // 6x6 instance: a single window then frame_done
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                ref6[r][c] = bit'($urandom_range(0, 1));
                e6[6*r+c]  = ref6[r][c];
            end
        for (int i = 0; i < 36; i++) begin
            pix_valid6 = 1'b1;
            pix_in6    = ref6[i / 6][i % 6];
            chk("l6_pix_ready", pix_ready6, 1);
            step();
        end
        pix_valid6 = 1'b0;
        win_ready6 = 1'b0;
        chk("w6_valid", win_valid6, 1);
        chk("w6_row", win_row6, 0);
        chk("w6_col", win_col6, 0);
        chk("w6_image", img6_v, e6);
        step();
        chk("w6_stall_valid", win_valid6, 1);
        chk("w6_stall_image", img6_v, e6);
        win_ready6 = 1'b1;
        step();
        win_ready6 = 1'b0;
        chk("w6_done_pulse", frame_done6, 1);
        chk("w6_done_win_valid", win_valid6, 0);
        chk("w6_done_pix_ready", pix_ready6, 0);
        step();
        chk("w6_after_done", frame_done6, 0);
        chk("w6_after_pix_ready", pix_ready6, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
